// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: colour in from the pixel source, sync/blanked colour
// and position/strobe outputs toward the DAC and the pixel source.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic [3:0]    pix_r;
  logic [3:0]    pix_g;
  logic [3:0]    pix_b;
  logic          HS;
  logic          VS;
  logic [3:0]    R;
  logic [3:0]    G;
  logic [3:0]    B;
  logic          active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          pix_tick;
  logic          frame_start;

  modport master (
    input  pix_r, pix_g, pix_b,
    output HS, VS, R, G, B, active, x, y, pix_tick, frame_start
  );

  modport slave (
    output pix_r, pix_g, pix_b,
    input  HS, VS, R, G, B, active, x, y, pix_tick, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: clock prescaler, horizontal/vertical counters and
// registered sync, blanking, coordinate and frame-start outputs.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  vga_timing_gen_if.master    vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Region bounds are one bit wider so an end bound equal to 2^CW still fits.
  localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG    = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG    = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]    div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          wrap_q, wrap_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          act_q, act_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          fs_q, fs_d;
  logic          tick;

  // Pixel strobe: last prescaler phase while running; forced low in reset.
  always_comb begin
    tick = rst_n & en & (div_q == DIV_LAST);
  end

  // Prescaler and raster counters; wrap_d marks the edge that returns to 0,0.
  always_comb begin
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    wrap_d = wrap_q;
    if (en) begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
      wrap_d = 1'b0;
      if (tick) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d    = '0;
            wrap_d = 1'b1;
          end else begin
            v_d = v_q + ONE;
          end
        end else begin
          h_d = h_q + ONE;
        end
      end
    end
  end

  // Output decode from the current counters, registered one clk later;
  // frame_start fires on the update that follows the 0,0 wrap.
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    act_d = act_q;
    x_d   = x_q;
    y_d   = y_q;
    rgb_d = rgb_q;
    fs_d  = 1'b0;
    if (en) begin
      hs_d  = ({1'b0, h_q} >= HS_BEG && {1'b0, h_q} < HS_END) ? HS_POL : ~HS_POL;
      vs_d  = ({1'b0, v_q} >= VS_BEG && {1'b0, v_q} < VS_END) ? VS_POL : ~VS_POL;
      act_d = ({1'b0, h_q} < H_ACT_END) && ({1'b0, v_q} < V_ACT_END);
      x_d   = act_d ? h_q : '0;
      y_d   = act_d ? v_q : '0;
      rgb_d = act_d ? {vid.pix_r, vid.pix_g, vid.pix_b} : '0;
      fs_d  = wrap_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      wrap_q <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      act_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      rgb_q  <= '0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      wrap_q <= wrap_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      act_q  <= act_d;
      x_q    <= x_d;
      y_q    <= y_d;
      rgb_q  <= rgb_d;
      fs_q   <= fs_d;
    end
  end

  assign vid.HS          = hs_q;
  assign vid.VS          = vs_q;
  assign vid.R           = rgb_q[11:8];
  assign vid.G           = rgb_q[7:4];
  assign vid.B           = rgb_q[3:0];
  assign vid.active      = act_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.pix_tick    = tick;
  // Gated so a pulse registered just before a pause never shows while paused.
  assign vid.frame_start = fs_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: three configurations checked each
// clk against an arithmetic raster model, plus measured period checks.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct {
    int d;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        fs;
  } vo_t;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        en    [3];
  logic [11:0] pix   [3];
  vo_t         obs   [3];
  logic        tck   [3];

  int          n_tests = 0;
  int          n_fail  = 0;

  // model state: enabled edges since reset, last sampled colour, last edge enabled
  int          k  [3];
  logic [11:0] lp [3];
  logic        le [3];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) ifa ();
  vga_timing_gen_if #(.CW(10)) ifb ();
  vga_timing_gen_if #(.CW(10)) ifc ();

  vga_timing_gen #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .vid(ifa.master));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
  ) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .vid(ifb.master));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(10)
  ) dut_c (
    .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .vid(ifc.master));

  assign {ifa.pix_r, ifa.pix_g, ifa.pix_b} = pix[0];
  assign {ifb.pix_r, ifb.pix_g, ifb.pix_b} = pix[1];
  assign {ifc.pix_r, ifc.pix_g, ifc.pix_b} = pix[2];

  assign obs[0] = {ifa.HS, ifa.VS, ifa.active, ifa.x, ifa.y, ifa.R, ifa.G, ifa.B, ifa.frame_start};
  assign obs[1] = {ifb.HS, ifb.VS, ifb.active, ifb.x, ifb.y, ifb.R, ifb.G, ifb.B, ifb.frame_start};
  assign obs[2] = {ifc.HS, ifc.VS, ifc.active, ifc.x, ifc.y, ifc.R, ifc.G, ifc.B, ifc.frame_start};
  assign tck[0] = ifa.pix_tick;
  assign tck[1] = ifb.pix_tick;
  assign tck[2] = ifc.pix_tick;

  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    case (i)
      0:       c = '{d:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};
      1:       c = '{d:1, ha:8,   hf:2,  hs:3,  hb:3,  va:4,   vf:1,  vs:1, vb:2,  hp:1'b1, vp:1'b1};
      default: c = '{d:3, ha:10,  hf:2,  hs:3,  hb:1,  va:5,   vf:1,  vs:2, vb:2,  hp:1'b1, vp:1'b0};
    endcase
    return c;
  endfunction

  // Outputs after k enabled edges reflect the raster position reached after
  // k-1 edges: (k-1)/d pixel ticks taken, modulo the frame size.
  function automatic vo_t model_vo(input cfg_t c, input int kk, input logic [11:0] px);
    vo_t o;
    int ht, vt, m, t, p, h, v;
    ht    = c.ha + c.hf + c.hs + c.hb;
    vt    = c.va + c.vf + c.vs + c.vb;
    o.hs  = !c.hp;
    o.vs  = !c.vp;
    o.act = 1'b0;
    o.x   = '0;
    o.y   = '0;
    o.rgb = '0;
    o.fs  = 1'b0;
    if (kk > 0) begin
      m     = kk - 1;
      t     = m / c.d;
      p     = t % (ht * vt);
      h     = p % ht;
      v     = p / ht;
      o.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
      o.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
      o.act = (h < c.ha) && (v < c.va);
      if (o.act) begin
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.rgb = px;
      end
      o.fs = (m % c.d == 0) && (t > 0) && (p == 0);
    end
    return o;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        k[i]  = 0;
        lp[i] = '0;
        le[i] = 1'b0;
      end else begin
        le[i] = en[i];
        if (en[i]) begin
          k[i]  = k[i] + 1;
          lp[i] = pix[i];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_dut(input int i);
    cfg_t c;
    vo_t  e;
    logic et;
    c = get_cfg(i);
    if (!rst_n[i]) begin
      e  = model_vo(c, 0, '0);
      et = 1'b0;
    end else begin
      e    = model_vo(c, k[i], lp[i]);
      e.fs = e.fs & en[i] & le[i];
      et   = en[i] && (k[i] % c.d == c.d - 1);
    end
    check($sformatf("dut%0d_out", i), 64'(obs[i]), 64'(e));
    check($sformatf("dut%0d_tick", i), 64'(tck[i]), 64'(et));
  endtask

  int   qa_on[$], qa_off[$];
  int   qb_on[$], qb_off[$], qb_vs_on[$], qb_vs_off[$], qb_fs[$];
  logic pa_hs, pb_hs, pb_vs;
  int   frz_left;
  bit   frz_done;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      pix[i]   = '0;
    end
    en[0] = 1'b0;
    en[1] = 1'b1;
    en[2] = 1'b0;
    frz_left = 0;
    frz_done = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_dut(i);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    en[0]  = 1'b1;
    en[2]  = 1'b1;
    pix[0] = 12'hFA5;
    pa_hs  = ifa.HS;
    pb_hs  = ifb.HS;
    pb_vs  = ifb.VS;

    for (int cyc = 0; cyc < 11000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_dut(i);

      if (cyc < 7000) begin
        if (pa_hs && !ifa.HS) qa_on.push_back(cyc);
        if (!pa_hs && ifa.HS) qa_off.push_back(cyc);
      end
      if (!pb_hs && ifb.HS) qb_on.push_back(cyc);
      if (pb_hs && !ifb.HS) qb_off.push_back(cyc);
      if (!pb_vs && ifb.VS) qb_vs_on.push_back(cyc);
      if (pb_vs && !ifb.VS) qb_vs_off.push_back(cyc);
      if (ifb.frame_start) qb_fs.push_back(cyc);
      pa_hs = ifa.HS;
      pb_hs = ifb.HS;
      pb_vs = ifb.VS;

      // A: one 37-clk pause at h_cnt 655, then an asynchronous reset mid-frame
      if (frz_left > 0) begin
        frz_left--;
        if (frz_left == 0) en[0] = 1'b1;
      end else if (!frz_done && k[0] > 0 && ((k[0] / 4) % 800) == 655) begin
        en[0]    = 1'b0;
        frz_left = 37;
        frz_done = 1'b1;
      end
      if (cyc == 7003) rst_n[0] = 1'b1;

      // B: free running with random colour
      pix[1] = 12'($urandom);

      // C: random pauses, colour and periodic resets
      en[2]  = ($urandom_range(0, 3) != 0);
      pix[2] = 12'($urandom);
      if (cyc % 1500 == 700) rst_n[2] = 1'b0;
      if (cyc % 1500 == 702) rst_n[2] = 1'b1;

      if (cyc == 7000) begin
        #2 rst_n[0] = 1'b0;
        #1 check_dut(0);
        check("A_async_hs", 64'(ifa.HS), 64'(1));
      end
    end

    check("A_hs_edges", 64'(qa_on.size() >= 2 && qa_off.size() >= 2), 64'(1));
    if (qa_on.size() >= 2 && qa_off.size() >= 2) begin
      check("A_line_clk", 64'(qa_on[1] - qa_on[0]), 64'(3200));
      check("A_hs_width", 64'(qa_off[1] - qa_on[1]), 64'(384));
    end
    check("B_edges", 64'(qb_on.size() >= 3 && qb_off.size() >= 2 &&
                         qb_vs_on.size() >= 2 && qb_vs_off.size() >= 1 &&
                         qb_fs.size() >= 3), 64'(1));
    if (qb_on.size() >= 3 && qb_off.size() >= 2 && qb_vs_on.size() >= 2 &&
        qb_vs_off.size() >= 1 && qb_fs.size() >= 3) begin
      check("B_line_clk", 64'(qb_on[2] - qb_on[1]), 64'(16));
      check("B_hs_width", 64'(qb_off[1] - qb_on[1]), 64'(3));
      check("B_vs_width", 64'(qb_vs_off[0] - qb_vs_on[0]), 64'(16));
      check("B_frame_vs", 64'(qb_vs_on[1] - qb_vs_on[0]), 64'(128));
      check("B_frame_fs", 64'(qb_fs[2] - qb_fs[1]), 64'(128));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
